// File: rtl/gpio_pkg.sv
// Shared constants and register decode for the GPIO bus responder.
package gpio_pkg;

   localparam logic [31:0] GPIO_BASE = 32'h0200_0000;
   localparam int          WIN_BITS  = 8;

   localparam logic [7:0] OFS_DATA_OUT = 8'h00;
   localparam logic [7:0] OFS_DIR      = 8'h04;
   localparam logic [7:0] OFS_DATA_IN  = 8'h08;
   localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
   localparam logic [7:0] OFS_IRQ_STAT = 8'h10;
   localparam logic [7:0] OFS_TOGGLE   = 8'h14;

   typedef enum logic [2:0] {
      SEL_NONE     = 3'd0,
      SEL_DATA_OUT = 3'd1,
      SEL_DIR      = 3'd2,
      SEL_DATA_IN  = 3'd3,
      SEL_IRQ_EN   = 3'd4,
      SEL_IRQ_STAT = 3'd5,
      SEL_TOGGLE   = 3'd6
   } reg_sel_e;

   // Byte lanes within a word are ignored, so only ofs[7:2] selects.
   function automatic reg_sel_e decode_sel(input logic [7:0] ofs);
      reg_sel_e sel;
      case ({ofs[7:2], 2'b00})
         OFS_DATA_OUT: sel = SEL_DATA_OUT;
         OFS_DIR:      sel = SEL_DIR;
         OFS_DATA_IN:  sel = SEL_DATA_IN;
         OFS_IRQ_EN:   sel = SEL_IRQ_EN;
         OFS_IRQ_STAT: sel = SEL_IRQ_STAT;
         OFS_TOGGLE:   sel = SEL_TOGGLE;
         default:      sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Pin input path: two-flop synchronizer, edge detect and post-reset warm-up mask.
module gpio_in_sync
   import gpio_pkg::*;
#(
   parameter int GPIO_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] pin_i,
   output logic [GPIO_W-1:0] sync_o,
   output logic [GPIO_W-1:0] rise_o
);

   logic [GPIO_W-1:0] meta_q;
   logic [GPIO_W-1:0] sync_q;
   logic [GPIO_W-1:0] prev_q;
   logic [1:0]        warm_q;
   logic [1:0]        warm_d;
   logic              warm_done_s;

   assign warm_done_s = (warm_q == 2'd3);

   // Warm-up counter saturates at 3 so pins already high at reset release are not seen as edges.
   always_comb begin
      warm_d = warm_q;
      if (!warm_done_s) begin
         warm_d = warm_q + 2'd1;
      end else begin
         warm_d = warm_q;
      end
   end

   // Synchronizer, delayed copy and warm-up state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= {GPIO_W{1'b0}};
         sync_q <= {GPIO_W{1'b0}};
         prev_q <= {GPIO_W{1'b0}};
         warm_q <= 2'd0;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         warm_q <= warm_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q & {GPIO_W{warm_done_s}};

endmodule

// File: rtl/gpio_responder.sv
// GPIO peripheral on the CPU address/data bus: output/direction registers,
// synchronized input readback and sticky rising-edge interrupt status.
module gpio_responder
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = GPIO_BASE,
   parameter int          GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              we,
   output logic [31:0]       rdata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              irq
);

   logic [GPIO_W-1:0] out_q,  out_d;
   logic [GPIO_W-1:0] dir_q,  dir_d;
   logic [GPIO_W-1:0] en_q,   en_d;
   logic [GPIO_W-1:0] stat_q, stat_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q,  irq_d;

   logic [GPIO_W-1:0] sync_s;
   logic [GPIO_W-1:0] rise_s;
   logic [GPIO_W-1:0] wval_s;
   logic [GPIO_W-1:0] clr_s;
   logic [GPIO_W-1:0] rd_val_s;
   logic              hit_s;
   logic              wr_s;
   reg_sel_e          sel_s;
   logic              unused_s;

   gpio_in_sync #(
      .GPIO_W (GPIO_W)
   ) u_in_sync (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (gpio_in),
      .sync_o (sync_s),
      .rise_o (rise_s)
   );

   assign hit_s    = (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign sel_s    = decode_sel(addr[WIN_BITS-1:0]);
   assign wr_s     = we & hit_s;
   assign wval_s   = wdata[GPIO_W-1:0];
   assign unused_s = ^{addr[1:0], wdata};

   // Register write decode; a W1C clear on the same bit as a new rise loses to the rise.
   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      en_d  = en_q;
      clr_s = {GPIO_W{1'b0}};
      if (wr_s) begin
         case (sel_s)
            SEL_DATA_OUT: out_d = wval_s;
            SEL_DIR:      dir_d = wval_s;
            SEL_IRQ_EN:   en_d  = wval_s;
            SEL_IRQ_STAT: clr_s = wval_s;
            SEL_TOGGLE:   out_d = out_q ^ wval_s;
            default:      out_d = out_q;
         endcase
      end else begin
         out_d = out_q;
      end
      stat_d = (stat_q & ~clr_s) | rise_s;
      irq_d  = |(stat_q & en_q);
   end

   // Read mux reflects pre-write register state; misses and write-only offsets read 0.
   always_comb begin
      rd_val_s = {GPIO_W{1'b0}};
      if (hit_s) begin
         case (sel_s)
            SEL_DATA_OUT: rd_val_s = out_q;
            SEL_DIR:      rd_val_s = dir_q;
            SEL_DATA_IN:  rd_val_s = sync_s;
            SEL_IRQ_EN:   rd_val_s = en_q;
            SEL_IRQ_STAT: rd_val_s = stat_q;
            default:      rd_val_s = {GPIO_W{1'b0}};
         endcase
      end else begin
         rd_val_s = {GPIO_W{1'b0}};
      end
      rdata_d               = 32'h0000_0000;
      rdata_d[GPIO_W-1:0]   = rd_val_s;
   end

   // Architectural registers and registered bus outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= {GPIO_W{1'b0}};
         dir_q   <= {GPIO_W{1'b0}};
         en_q    <= {GPIO_W{1'b0}};
         stat_q  <= {GPIO_W{1'b0}};
         rdata_q <= 32'h0000_0000;
         irq_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
         stat_q  <= stat_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign rdata    = rdata_q;
   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;

endmodule

// File: doc/gpio_responder.md
Name: gpio_responder

Overview:
- Bus-side responder for the MCU's single-master address/data bus: addr, wdata, we driven by the CPU; rdata returned.
- Implements the GPIO peripheral decoded at BASE_ADDR (default 0x0200_0000), the address the CPU's boot sequence writes and reads.
- Provides output/direction registers, a synchronized input readback, and sticky rising-edge interrupt status with a level irq output.

Parameters:
- BASE_ADDR, 32'h0200_0000, peripheral base; window is 256 bytes.
- GPIO_W, 8, number of GPIO pins, range 1..32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from CPU, valid every cycle.
- wdata  in  32  write data, sampled when we=1.
- we  in  1  write strobe; one write per cycle where we=1.
- rdata  out  32  registered read data.
- gpio_in  in  GPIO_W  asynchronous pin inputs.
- gpio_out  out  GPIO_W  pin output values (DATA_OUT).
- gpio_oe  out  GPIO_W  pin output enables (DIR, 1=drive).
- irq  out  1  registered interrupt request, level.

Behaviour:
- Reset is asynchronous, active-high, with one clock. While rst=1, all of the following are 0: rdata, gpio_out, gpio_oe, irq, IRQ_EN, IRQ_STAT, sync stages, prev stage, and the warm-up counter.
- Decode: hit = (addr[31:8] == BASE_ADDR[31:8]). Register is selected by addr[7:2]; addr[1:0] is ignored.
- Register map (offset, access):
  - 0x00 DATA_OUT, RW.
  - 0x04 DIR, RW.
  - 0x08 DATA_IN, RO; returns the synchronized pins regardless of DIR.
  - 0x0C IRQ_EN, RW.
  - 0x10 IRQ_STAT, W1C.
  - 0x14 TOGGLE, WO; writing XORs wdata into DATA_OUT and reads return 0.
- Writes:
  - Take effect at the clk edge where we=1 and hit=1. The new value is visible on gpio_out/gpio_oe immediately after that edge.
  - Only wdata[GPIO_W-1:0] is used.
  - Writes to a miss, to an unmapped offset, or to DATA_IN are ignored.
- Reads:
  - No read strobe. Every edge, rdata is loaded with the value selected by the current addr, so latency is one cycle.
  - Miss or unmapped offset returns 0. rdata[31:GPIO_W] is always 0.
  - Reads have no side effects.
- Read/write same cycle, same register: rdata gets the pre-write value. The following cycle shows the new value.
- Input path:
  - Two-flop synchronizer on gpio_in produces sync.
  - A prev flop holds sync delayed by one cycle.
  - rise = sync & ~prev.
- Warm-up:
  - A 2-bit counter increments from 0 to 3 after reset release and saturates.
  - rise is masked until the counter reaches 3. A pin held high through reset therefore causes no status event.
- IRQ_STAT:
  - A bit is set on unmasked rise, regardless of IRQ_EN.
  - A bit is cleared by a write of 1 to that bit at offset 0x10.
  - If set and clear hit the same bit in the same cycle, set wins.
- irq: registered. irq <= |(IRQ_STAT & IRQ_EN), so it follows the register state with one-cycle delay.
- Latency from a pin rising before edge t:
  - sync is high after edge t+1.
  - The IRQ_STAT bit is set at edge t+2.
  - irq is asserted at edge t+3 if the bit is enabled.
  - A DATA_IN read reflects the pin at the earliest for an addr presented in the cycle after edge t+1.
- Pin pulses shorter than one clk period may be missed; this is accepted, not an error.
- Reset asserted mid-operation clears all state immediately, including a pending irq. The warm-up sequence restarts on release.

Decomposition:
- gpio_pkg:
  - Register offset constants: OFS_DATA_OUT, OFS_DIR, OFS_DATA_IN, OFS_IRQ_EN, OFS_IRQ_STAT, OFS_TOGGLE.
  - Default base GPIO_BASE = 32'h0200_0000.
  - Window width constant WIN_BITS = 8.
- Sub-module gpio_in_sync:
  - Parameterised by GPIO_W.
  - Contains the two-flop synchronizer, the prev flop, the warm-up counter and masking.
  - Outputs sync[GPIO_W] and rise[GPIO_W].
- The top module holds decode, registers, W1C logic and the rdata mux/register.

Test Plan:
- Reset, then write 0x000000A5 to 0x0200_0000 with we=1 for 1 cycle → gpio_out=0xA5 after that edge. Present addr 0x0200_0000 with we=0 → rdata=0x000000A5 next cycle.
- Write DIR=0x0F, then TOGGLE with 0xFF → gpio_oe=0x0F, gpio_out=0x5A. A read of 0x0200_0014 returns 0. A read of 0x0300_0000 returns 0 and leaves all registers unchanged.
- gpio_in=0x00→0x04 with IRQ_EN=0x04 → IRQ_STAT=0x04 at edge t+2, irq=1 at t+3. Write 0x04 to offset 0x10 → irq=0 one cycle after the status clears.
- W1C of bit 2 in the same cycle as a new unmasked rise on pin 2 → IRQ_STAT[2] stays 1 and irq stays asserted.
- Hold gpio_in=0xFF through reset and release → IRQ_STAT remains 0x00. DATA_IN reads 0xFF from cycle 3 after release.
- Assert rst while irq=1 and DATA_OUT=0xA5 → irq, gpio_out, gpio_oe and rdata go to 0 without waiting for a clk edge.
